spi_shift_engine: RTL
=====================

Name: spi_shift_engine

Overview:
- Serial data path of the SPI master.
- Sits directly downstream of the SPI clock generator and consumes its one-cycle pos_edge/neg_edge pulses.
- Drives s_out and samples s_in on the selected edges. Holds a MAX_CHAR-bit shared TX/RX buffer.
- Returns tip (drives clock-generator enable) and last (drives clock-generator last_clk), closing the loop that stops the serial clock after the final bit.

Parameters:
- MAX_CHAR, 32, buffer width and maximum character length in bits; power of two, 8..128.
- LEN_BITS, 5, width of len; equals log2(MAX_CHAR).

Ports:
- clk_in  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  load buffer from wr_data; honoured only when tip=0
- wr_data  in  MAX_CHAR  parallel TX data
- go  in  1  start pulse; honoured only when tip=0
- len  in  LEN_BITS  character length; 0 means MAX_CHAR bits
- lsb  in  1  1 = LSB first, 0 = MSB first
- tx_negedge  in  1  1 = drive s_out on neg_edge, 0 = on pos_edge
- rx_negedge  in  1  1 = sample s_in on neg_edge, 0 = on pos_edge
- pos_edge  in  1  pulse from clock generator
- neg_edge  in  1  pulse from clock generator
- s_in  in  1  serial input (MISO)
- s_out  out  1  serial output (MOSI)
- tip  out  1  transfer in progress
- last  out  1  all bits driven; to clock generator last_clk
- rx_data  out  MAX_CHAR  buffer contents

Behaviour:
- Reset values: tip=0, s_out=0, buffer=0, tx_cnt=0, rx_cnt=0. last is combinational (tx_cnt==0), so it is 1 in reset.
- len_eff is MAX_CHAR if len==0, else len. It is computed LEN_BITS+1 wide.
- Idle (tip=0), wr_en=1: buffer <= wr_data next cycle.
- Idle, go=1: tip<=1, tx_cnt<=len_eff, rx_cnt<=len_eff next cycle.
- wr_en and go in the same cycle: both take effect. The transfer uses the new data, because no shift occurs until the first edge pulse.
- While tip=1, wr_en and go are ignored. The buffer changes only through RX sampling.
- tx_edge = tx_negedge ? neg_edge : pos_edge. rx_edge = rx_negedge ? neg_edge : pos_edge. Edge pulses are ignored while tip=0.
- TX, on tx_edge with tip=1 and tx_cnt!=0:
  - s_out <= buffer[tx_idx], tx_cnt <= tx_cnt-1.
  - tx_idx = lsb ? len_eff-tx_cnt : tx_cnt-1, using the pre-decrement value.
- RX, on rx_edge with tip=1 and rx_cnt!=0:
  - buffer[rx_idx] <= s_in, rx_cnt <= rx_cnt-1.
  - rx_idx uses the same formula with rx_cnt.
- Counters are independent, so TX and RX on the same edge are legal. Both read pre-decrement state in that cycle.
- Completion: an rx_edge with rx_cnt==1 clears tip the following cycle. Bits above len_eff-1 are never touched.
- last=1 once tx_cnt reaches 0. The clock generator then stops after its current phase.
- s_out holds its last driven value after completion and while idle.
- Short characters in MSB-first mode use buffer[len_eff-1:0]. The LSB-first index also stays within [len_eff-1:0].
- Reset asserted mid-transfer aborts immediately: all state returns to reset values, and no partial rx_data is preserved.
- Counter arithmetic is LEN_BITS+1 wide and unsigned. Underflow cannot occur because decrements are guarded by cnt!=0.

Decomposition:
- Shared package: MAX_CHAR and LEN_BITS defaults, and the len==0 → MAX_CHAR convention, for reuse by the clock generator and the register block.
- One natural sub-module: spi_bit_counter. It covers load, guarded decrement, the zero flag and the index generation for lsb/msb. It is instantiated twice, once for TX and once for RX.

Test Plan:
- len=8, lsb=0, tx_negedge=1, rx_negedge=0, wr_data=0xA5, s_in looped to s_out.
  Required: s_out sequence 1,0,1,0,0,1,0,1; rx_data[7:0]=0xA5; tip falls after the 8th pos_edge.
- len=8, lsb=1, same data, s_in tied 1.
  Required: s_out sequence 1,0,1,0,0,1,0,1 (LSB first); rx_data=0x000000FF.
- len=0 (32 bits), wr_data=0x80000001, MSB first, s_in=0.
  Required: 32 tx_edges; first bit 1, last bit 1; rx_data=0; last rises with the 32nd tx_edge.
- During tip: pulse wr_data=0xFFFF and go.
  Required: buffer and counters are unaffected; the transfer completes normally.
- Assert rst after 3 bits of an 8-bit transfer.
  Required: tip=0, s_out=0, rx_data=0, last=1 immediately. A subsequent go starts cleanly.
- tx_negedge=0, rx_negedge=0 (same edge), len=4.
  Required: TX and RX both occur on each of 4 pos_edges; tip clears after the 4th.

Source files
------------

// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI master serial path: default character
// geometry, the transfer state encoding and the len==0 -> MAX_CHAR rule.
package spi_shift_engine_pkg;

  localparam int MAX_CHAR_DEF = 32;
  localparam int LEN_BITS_DEF = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } xfer_state_e;

  // A programmed length of zero encodes a full-width character.
  function automatic int unsigned char_len(input int unsigned len,
                                           input int unsigned max_char);
    return (len == 0) ? max_char : len;
  endfunction

endpackage

// File: rtl/spi_shift_engine_bit_counter.sv
// Bit counter for one direction of the serial path: loads the character
// length, counts down on qualified edges (never below zero) and turns the
// remaining count into a buffer index for LSB-first or MSB-first order.
module spi_bit_counter #(
  parameter int LEN_BITS = 5
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                load,
  input  logic [LEN_BITS:0]   len_eff,
  input  logic                step,
  input  logic                lsb,
  output logic [LEN_BITS:0]   cnt,
  output logic [LEN_BITS-1:0] idx
);

  localparam int CW = LEN_BITS + 1;

  // Load on start, otherwise decrement while bits remain.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len_eff;
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Index of the bit handled by the next step, from the pre-decrement count;
  // both orders stay inside [len_eff-1:0].
  always_comb begin
    idx = '0;
    if (lsb) idx = LEN_BITS'(len_eff - cnt);
    else     idx = LEN_BITS'(cnt - CW'(1));
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master serial data path. Consumes the clock generator's edge pulses,
// drives s_out / samples s_in from a shared TX/RX buffer, and reports tip
// and last back to the clock generator.
//
// Handshake: wr_en and go are single-cycle requests accepted only while
// tip=0; they are silently dropped while a transfer is in progress.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int MAX_CHAR = MAX_CHAR_DEF,
  parameter int LEN_BITS = LEN_BITS_DEF
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [MAX_CHAR-1:0] wr_data,
  input  logic                go,
  input  logic [LEN_BITS-1:0] len,
  input  logic                lsb,
  input  logic                tx_negedge,
  input  logic                rx_negedge,
  input  logic                pos_edge,
  input  logic                neg_edge,
  input  logic                s_in,
  output logic                s_out,
  output logic                tip,
  output logic                last,
  output logic [MAX_CHAR-1:0] rx_data
);

  localparam int CW = LEN_BITS + 1;

  xfer_state_e         state;
  logic [MAX_CHAR-1:0] buffer;
  logic [CW-1:0]       len_eff;
  logic [CW-1:0]       tx_cnt;
  logic [CW-1:0]       rx_cnt;
  logic [LEN_BITS-1:0] tx_idx;
  logic [LEN_BITS-1:0] rx_idx;
  logic                tx_edge;
  logic                rx_edge;
  logic                start;

  assign len_eff = CW'(char_len(32'(len), MAX_CHAR));
  assign tx_edge = tx_negedge ? neg_edge : pos_edge;
  assign rx_edge = rx_negedge ? neg_edge : pos_edge;
  assign start   = (state == ST_IDLE) && go;
  assign tip     = (state == ST_XFER);
  assign last    = (tx_cnt == '0);
  assign rx_data = buffer;

  spi_bit_counter #(.LEN_BITS(LEN_BITS)) u_tx_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .load    (start),
    .len_eff (len_eff),
    .step    (tip && tx_edge),
    .lsb     (lsb),
    .cnt     (tx_cnt),
    .idx     (tx_idx)
  );

  spi_bit_counter #(.LEN_BITS(LEN_BITS)) u_rx_cnt (
    .clk_in  (clk_in),
    .rst     (rst),
    .load    (start),
    .len_eff (len_eff),
    .step    (tip && rx_edge),
    .lsb     (lsb),
    .cnt     (rx_cnt),
    .idx     (rx_idx)
  );

  // Transfer FSM with buffer load, TX drive and RX sampling; TX reads the
  // buffer before any RX write of the same cycle lands.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      s_out  <= 1'b0;
      buffer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) buffer <= wr_data;
          if (go)    state  <= ST_XFER;
        end
        ST_XFER: begin
          if (tx_edge && (tx_cnt != '0)) s_out <= buffer[tx_idx];
          if (rx_edge && (rx_cnt != '0)) begin
            buffer[rx_idx] <= s_in;
            if (rx_cnt == CW'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
